// File: rtl/sisc_pkg.sv
// Shared definitions for the write-back path: default widths and the
// encoding used to name the two write-back sources.
package sisc_pkg;

  localparam int DW = 32;
  localparam int RW = 4;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a write-back source. Holds the
// destination register, the data, and an age bit that says whether this
// entry arrived before the entry held in the other source's slot.
module wb_slot
  import sisc_pkg::*;
#(
  parameter int DW = sisc_pkg::DW,
  parameter int RW = sisc_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          flush,
  input  logic          load,
  input  logic          grant,
  input  logic [RW-1:0] load_reg,
  input  logic [DW-1:0] load_data,
  input  logic          age_next,
  output logic          full,
  output logic [RW-1:0] dest,
  output logic [DW-1:0] data,
  output logic          age
);

  // Slot state: a new load wins over the grant that empties the slot, so a
  // source can stream one entry per cycle while it keeps being granted.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      full <= 1'b0;
      dest <= '0;
      data <= '0;
      age  <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
      age  <= 1'b0;
    end else begin
      if (load) begin
        full <= 1'b1;
        dest <= load_reg;
        data <= load_data;
      end else if (grant) begin
        full <= 1'b0;
      end
      age <= age_next;
    end
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Register file write-port arbiter. Two write-back sources (ALU and load
// unit) each feed a one-entry slot; one slot per cycle is granted into a
// registered output stage that drives the register file write port.
module rf_wr_arb #(
  parameter int DW = sisc_pkg::DW,
  parameter int RW = sisc_pkg::RW
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [RW-1:0]    alu_reg,
  input  logic [DW-1:0]    alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [RW-1:0]    ld_reg,
  input  logic [DW-1:0]    ld_data,
  input  logic             flush,
  output logic             rf_we,
  output logic [RW-1:0]    rf_wreg,
  output logic [DW-1:0]    rf_wdata,
  output logic [2**RW-1:0] pend_mask
);

  import sisc_pkg::*;

  localparam int NREG = 2 ** RW;

  logic          alu_full, ld_full;
  logic [RW-1:0] alu_dest, ld_dest;
  logic [DW-1:0] alu_held, ld_held;
  logic          alu_age, ld_age;
  logic          alu_age_next, ld_age_next;
  logic          alu_grant, ld_grant;
  logic          alu_load, ld_load;
  logic          alu_keep, ld_keep;
  src_e          prio;

  // A slot can accept when it is empty or is being drained this cycle.
  // Requests to register 0 still handshake but never occupy a slot.
  assign alu_ready = !rst_f && !flush && (!alu_full || alu_grant);
  assign ld_ready  = !rst_f && !flush && (!ld_full  || ld_grant);
  assign alu_load  = alu_valid && alu_ready && (alu_reg != '0);
  assign ld_load   = ld_valid  && ld_ready  && (ld_reg  != '0);
  assign alu_keep  = alu_full && !alu_grant;
  assign ld_keep   = ld_full  && !ld_grant;

  // Age tracking: a slot that stays full while the other one loads becomes
  // the older entry; on a same-edge load the load unit counts as older.
  always_comb begin
    alu_age_next = 1'b0;
    ld_age_next  = 1'b0;
    if (ld_load)
      ld_age_next = !alu_keep;
    else if (ld_keep)
      ld_age_next = alu_load ? 1'b1 : ld_age;
    if (alu_load)
      alu_age_next = ld_load ? 1'b0 : !ld_keep;
    else if (alu_keep)
      alu_age_next = ld_load ? 1'b1 : alu_age;
  end

  wb_slot #(.DW(DW), .RW(RW)) u_alu_slot (
    .clk       (clk),
    .rst_f     (rst_f),
    .flush     (flush),
    .load      (alu_load),
    .grant     (alu_grant),
    .load_reg  (alu_reg),
    .load_data (alu_data),
    .age_next  (alu_age_next),
    .full      (alu_full),
    .dest      (alu_dest),
    .data      (alu_held),
    .age       (alu_age)
  );

  wb_slot #(.DW(DW), .RW(RW)) u_ld_slot (
    .clk       (clk),
    .rst_f     (rst_f),
    .flush     (flush),
    .load      (ld_load),
    .grant     (ld_grant),
    .load_reg  (ld_reg),
    .load_data (ld_data),
    .age_next  (ld_age_next),
    .full      (ld_full),
    .dest      (ld_dest),
    .data      (ld_held),
    .age       (ld_age)
  );

  // Grant selection: two writes to the same register must retire in
  // arrival order, otherwise the round-robin pointer decides.
  always_comb begin
    alu_grant = 1'b0;
    ld_grant  = 1'b0;
    if (alu_full && ld_full) begin
      if (alu_dest == ld_dest) begin
        if (ld_age) ld_grant  = 1'b1;
        else        alu_grant = 1'b1;
      end else if (prio == SRC_LD) begin
        ld_grant = 1'b1;
      end else begin
        alu_grant = 1'b1;
      end
    end else if (alu_full) begin
      alu_grant = 1'b1;
    end else if (ld_full) begin
      ld_grant = 1'b1;
    end
  end

  // Output stage and round-robin pointer: the granted entry is presented
  // for exactly one cycle and the pointer moves to the losing source.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      rf_we    <= 1'b0;
      rf_wreg  <= '0;
      rf_wdata <= '0;
      prio     <= SRC_ALU;
    end else if (flush) begin
      rf_we    <= 1'b0;
      rf_wreg  <= '0;
      rf_wdata <= '0;
      prio     <= SRC_ALU;
    end else if (alu_grant) begin
      rf_we    <= 1'b1;
      rf_wreg  <= alu_dest;
      rf_wdata <= alu_held;
      prio     <= SRC_LD;
    end else if (ld_grant) begin
      rf_we    <= 1'b1;
      rf_wreg  <= ld_dest;
      rf_wdata <= ld_held;
      prio     <= SRC_ALU;
    end else begin
      rf_we    <= 1'b0;
      rf_wreg  <= '0;
      rf_wdata <= '0;
    end
  end

  // Pending flags: a register stays busy from slot load until its write
  // leaves the output stage; register 0 is never pending.
  always_comb begin
    pend_mask = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_mask[r] = (alu_full && (alu_dest == RW'(r))) ||
                     (ld_full  && (ld_dest  == RW'(r))) ||
                     (rf_we    && (rf_wreg  == RW'(r)));
    end
  end

endmodule
